// File: rtl/clocking_pkg.sv
// Shared types and helpers for the gated clock bank.
// The hold counter needs at least one bit even when no hold-off is configured.
package clocking_pkg;

  typedef enum logic [1:0] {
    GS_OFF  = 2'd0,
    GS_ON   = 2'd1,
    GS_HOLD = 2'd2
  } gate_state_e;

  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold == 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ch.sv
// One gated clock channel: enable synchroniser, gating FSM with hold-off counter,
// and a negedge-registered gate enable so clk_o pulses are never partial.
//
//  state   | meaning
//  GS_OFF  | clock gated, channel idle
//  GS_ON   | synchronised enable high, clock running
//  GS_HOLD | enable dropped, clock kept running while cnt drains to 0
module clk_gate_ch
  import clocking_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic en_i,
  output logic gate_en,
  output logic active
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_s;
  gate_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   gate_en_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], en_i};
  end

  assign en_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= GS_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GS_OFF: begin
        if (en_s) state_d = GS_ON;
      end
      GS_ON: begin
        if (!en_s) begin
          if (HOLD_CYCLES == 0) begin
            state_d = GS_OFF;
          end else begin
            state_d = GS_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      GS_HOLD: begin
        if (en_s)              state_d = GS_ON;
        else if (cnt_q == '0)  state_d = GS_OFF;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = GS_OFF;
    endcase
  end

  // Updating on the falling edge keeps the gate stable for the whole high phase.
  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) gate_en_q <= 1'b0;
    else          gate_en_q <= (state_q != GS_OFF);
  end

  assign gate_en = gate_en_q;
  assign active  = (state_q != GS_OFF);

endmodule

// File: rtl/clk_gate_bank.sv
// Bank of independent gated clock channels with a global test-mode bypass
// and an aggregate busy flag.
module clk_gate_bank
  import clocking_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] active_o,
  output logic              busy_o
);

  logic [NUM_CH-1:0] gate_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gate_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .en_i    (en_i[i]),
      .gate_en (gate_en[i]),
      .active  (active_o[i])
    );
  end

  // test_en_i is quasi-static; the bypass is a plain OR ahead of the AND gate.
  assign clk_o  = {NUM_CH{clk_i}} & (gate_en | {NUM_CH{test_en_i}});
  assign busy_o = |active_o;

endmodule

// File: tb/tb_clk_gate_bank.sv
// Directed bench for clk_gate_bank: hand-computed pulse positions plus a
// window model of enable history (pulse at edge n iff en seen in [n-S-1-H, n-S-1]).
module tb_clk_gate_bank;
  import clocking_pkg::*;

  logic       clk_i     = 1'b0;
  logic       arst_ni   = 1'b0;
  logic [3:0] en_i      = 4'hF;
  logic       test_en_i = 1'b0;
  logic [3:0] clk_o;
  logic [3:0] active_o;
  logic       busy_o;
  logic [0:0] h0_clk_o;
  logic [0:0] h0_active_o;
  logic       h0_busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_rst = 0;
  logic [3:0] ehist [0:2047];

  always #5 clk_i = ~clk_i;

  clk_gate_bank #(.NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(4)) dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .en_i      (en_i),
    .test_en_i (test_en_i),
    .clk_o     (clk_o),
    .active_o  (active_o),
    .busy_o    (busy_o)
  );

  clk_gate_bank #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(0)) dut_h0 (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .en_i      (en_i[0:0]),
    .test_en_i (test_en_i),
    .clk_o     (h0_clk_o),
    .active_o  (h0_active_o),
    .busy_o    (h0_busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] gate_model(input int n, input int h);
    logic [3:0] r;
    r = '0;
    for (int m = n - 3 - h; m <= n - 3; m++)
      if (m > last_rst && m >= 0) r = r | ehist[m];
    return r;
  endfunction

  // Advance to 2 time units after the next posedge and compare against the model.
  task automatic tick();
    logic [3:0] e_act;
    logic [3:0] h_act;
    @(posedge clk_i);
    cyc++;
    ehist[cyc] = arst_ni ? en_i : 4'h0;
    if (!arst_ni) last_rst = cyc;
    #2;
    e_act = gate_model(cyc + 1, 4);
    h_act = gate_model(cyc + 1, 0);
    check("model_clk_o", 32'(clk_o), 32'(gate_model(cyc, 4) | {4{test_en_i}}));
    check("model_active_o", 32'(active_o), 32'(e_act));
    check("model_busy_o", 32'(busy_o), 32'(|e_act));
    check("model_h0_clk_o", 32'(h0_clk_o), 32'(gate_model(cyc, 0) & 4'h1 | {3'b0, test_en_i}));
    check("model_h0_active_o", 32'(h0_active_o), 32'(h_act & 4'h1));
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    time  t_rise;
    logic seen = 1'b0;
    always @(posedge clk_o[g]) begin
      t_rise = $time;
      seen   = 1'b1;
    end
    always @(negedge clk_o[g]) begin
      if (seen) check("pulse_width", 32'($time - t_rise), 32'd5);
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) ehist[i] = 4'h0;

    // reset with all enables high
    repeat (3) tick();
    check("rst_clk_o", 32'(clk_o), 32'd0);
    check("rst_active_o", 32'(active_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    arst_ni = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("rst_first_pulse", 32'(clk_o[0]), 32'(j >= 4));
    end
    repeat (4) tick();

    // hold-off on channel 1: pulses k..k+6, none at k+7
    en_i[1] = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      tick();
      check("hold_clk_o1", 32'(clk_o[1]), 32'(j <= 6));
      check("hold_active_o1", 32'(active_o[1]), 32'(j <= 5));
    end

    // re-enable channel 2 while in hold
    en_i[2] = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      if (j == 2) en_i[2] = 1'b1;
      tick();
      check("rehold_clk_o2", 32'(clk_o[2]), 32'd1);
      if (j == 3) check("rehold_state_hold", 32'(dut.g_ch[2].u_ch.state_q), 32'(GS_HOLD));
      if (j == 4) check("rehold_state_on", 32'(dut.g_ch[2].u_ch.state_q), 32'(GS_ON));
    end

    // zero hold-off build: last pulse at k+2
    en_i[0] = 1'b0;
    for (int j = 0; j <= 3; j++) begin
      tick();
      check("h0_last_pulse", 32'(h0_clk_o), 32'(j <= 2));
    end

    // independent random toggling of channels 0 and 3
    en_i[3] = 1'($urandom_range(0, 1));
    for (int r = 0; r < 30; r++) begin
      en_i[0] = ~en_i[0];
      en_i[3] = ~en_i[3];
      repeat ($urandom_range(1, 8)) tick();
    end

    // bypass: switch test mode only while clk_i is low
    en_i = 4'h0;
    repeat (10) tick();
    check("idle_busy_o", 32'(busy_o), 32'd0);
    #5 test_en_i = 1'b1;
    repeat (3) begin
      tick();
      check("bypass_clk_o_hi", 32'(clk_o), 32'hF);
      check("bypass_active_o", 32'(active_o), 32'd0);
      #5;
      check("bypass_clk_o_lo", 32'(clk_o), 32'd0);
    end
    test_en_i = 1'b0;
    repeat (3) tick();
    check("post_bypass_clk_o", 32'(clk_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
